// File: rtl/adc_spi_responder_pkg.sv
// adc_spi_responder_pkg: constants and state type shared by the serial ADC responder and its controller
package adc_spi_responder_pkg;
    localparam int DATA_W          = 12;
    localparam int NCH             = 8;
    localparam int FRAME_LEN       = 16;
    localparam int SYNC_STG_DEF    = 2;
    localparam int LEAD_ZEROS      = 4;
    localparam int ADDR_RISE_FIRST = 3;
    localparam int ADDR_W          = 3;
    localparam int CNT_W           = $clog2(FRAME_LEN + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if: 4-wire serial ADC link (CS_n, SCLK, DIN from master; DOUT with pad enable from slave)
interface adc_spi_responder_if;
    logic sclk;
    logic cs_n;
    logic din;
    logic dout;
    logic dout_oe;
    modport master(output sclk, cs_n, din, input dout, dout_oe);
    modport slave(input sclk, cs_n, din, output dout, dout_oe);
endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// adc_spi_responder_sync_edge: multi-flop synchronizer with rise/fall pulses on the synced level
module adc_spi_responder_sync_edge #(
    parameter int   SYNC_STG = 2,
    parameter logic RST_VAL  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STG-1:0] sync;
    logic                prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync <= {SYNC_STG{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STG-2:0], d};
            prev <= sync[SYNC_STG-1];
        end
    assign level = sync[SYNC_STG-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: ADC128S022-style 8-channel 12-bit serial ADC slave emulator.
// Define ADC_RESP_ERRCNT_EN to enable the saturating aborted-frame counter on err_cnt.
module adc_spi_responder
    import adc_spi_responder_pkg::*;
#(
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    adc_spi_responder_if.slave      link,
    input  logic [NCH*DATA_W-1:0]   ch_data,
    output logic [ADDR_W-1:0]       ch,
    output logic                    frame_done,
    output logic [7:0]              err_cnt
);
    logic sclk_rise, sclk_fall, sclk_unused_lvl;
    logic cs_rise, cs_fall, cs_unused_lvl;
    logic din_lvl, din_unused_rise, din_unused_fall;
    state_t               state;
    logic [FRAME_LEN-1:0] shreg, load_w;
    logic [CNT_W-1:0]     rise_cnt, rise_n;
    logic [ADDR_W-1:0]    addr_nxt;
    adc_spi_responder_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(link.sclk), .level(sclk_unused_lvl), .rise(sclk_rise), .fall(sclk_fall));
    adc_spi_responder_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(link.cs_n), .level(cs_unused_lvl), .rise(cs_rise), .fall(cs_fall));
    adc_spi_responder_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_din (
        .clk(clk), .rst_n(rst_n), .d(link.din), .level(din_lvl), .rise(din_unused_rise), .fall(din_unused_fall));
    assign rise_n = rise_cnt + CNT_W'(1);
    assign load_w = {{LEAD_ZEROS{1'b0}}, ch_data[int'(ch)*DATA_W +: DATA_W]};
    // A CS_n event takes priority over any SCLK edge detected in the same cycle.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            rise_cnt     <= '0;
            addr_nxt     <= '0;
            ch           <= '0;
            frame_done   <= 1'b0;
            link.dout    <= 1'b0;
            link.dout_oe <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cs_rise) begin
                state        <= IDLE;
                link.dout    <= 1'b0;
                link.dout_oe <= 1'b0;
            end else if (cs_fall) begin
                state        <= SHIFT;
                shreg        <= load_w;
                rise_cnt     <= '0;
                link.dout    <= load_w[FRAME_LEN-1];
                link.dout_oe <= 1'b1;
            end else if (state == SHIFT && sclk_rise) begin
                rise_cnt <= rise_n;
                if (rise_n >= CNT_W'(ADDR_RISE_FIRST) && rise_n < CNT_W'(ADDR_RISE_FIRST + ADDR_W))
                    addr_nxt <= {addr_nxt[ADDR_W-2:0], din_lvl};
                if (rise_n == CNT_W'(FRAME_LEN)) begin
                    ch         <= addr_nxt;
                    frame_done <= 1'b1;
                    state      <= DONE;
                    link.dout  <= 1'b0;
                end
            end else if (state == SHIFT && sclk_fall && rise_cnt != '0) begin
                shreg     <= {shreg[FRAME_LEN-2:0], 1'b0};
                link.dout <= shreg[FRAME_LEN-2];
            end
        end
`ifdef ADC_RESP_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            err_cnt <= '0;
        else if (cs_rise && state == SHIFT && rise_cnt != '0 && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: drives master frames and checks DOUT words, channel tracking and aborts against a frame-level model
module tb_adc_spi_responder;
    localparam int HALF = 12;
    localparam int SYNC = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] ch_bus;
    logic [2:0]  ch;
    logic        frame_done;
    logic [7:0]  err_cnt;
    logic [11:0] chdata [8];
    logic [2:0]  ref_ch;
    int          ref_err;
    int          done_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    adc_spi_responder_if lnk();
    adc_spi_responder #(.SYNC_STG(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .link(lnk.slave), .ch_data(ch_bus),
        .ch(ch), .frame_done(frame_done), .err_cnt(err_cnt));
    always #5 clk = ~clk;
    always_comb for (int k = 0; k < 8; k++) ch_bus[k*12 +: 12] = chdata[k];
    always @(negedge clk) if (frame_done) done_cnt++;
    initial begin
        #3ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [7:0] exp_err();
`ifdef ADC_RESP_ERRCNT_EN
        return 8'(ref_err > 255 ? 255 : ref_err);
`else
        return 8'd0;
`endif
    endfunction
    task automatic run_frame(input string tag, input logic [2:0] addr, input int nrise, input bit mutate, input bit rst_end);
        logic [15:0] exp_bits, got;
        int d0, n;
        exp_bits = {4'b0, chdata[ref_ch]};
        got = '0;
        d0 = done_cnt;
        lnk.cs_n = 1'b0;
        wait_clks(HALF);
        chk({tag, "_oe_on"}, 32'(lnk.dout_oe), 32'd1);
        for (int k = 1; k <= nrise; k++) begin
            lnk.sclk = 1'b0;
            lnk.din = (k >= 3 && k <= 5) ? addr[5-k] : 1'($urandom);
            wait_clks(HALF);
            if (k <= 16) got[16-k] = lnk.dout;
            else chk({tag, "_dout_tail"}, 32'(lnk.dout), 32'd0);
            lnk.sclk = 1'b1;
            wait_clks(HALF);
            if (mutate && k == 8) chdata[ref_ch] = ~exp_bits[11:0];
        end
        n = nrise < 16 ? nrise : 16;
        if (n > 0) chk({tag, "_word"}, 32'(got >> (16 - n)), 32'(exp_bits >> (16 - n)));
        if (rst_end) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "_rst_oe"}, 32'(lnk.dout_oe), 32'd0);
            chk({tag, "_rst_ch"}, 32'(ch), 32'd0);
            chk({tag, "_rst_dout"}, 32'(lnk.dout), 32'd0);
            lnk.cs_n = 1'b1;
            wait_clks(3);
            rst_n = 1'b1;
            ref_ch = '0;
            ref_err = 0;
            wait_clks(HALF);
            return;
        end
        lnk.cs_n = 1'b1;
        wait_clks(SYNC + 1);
        chk({tag, "_oe_off"}, 32'(lnk.dout_oe), 32'd0);
        chk({tag, "_dout_off"}, 32'(lnk.dout), 32'd0);
        if (nrise >= 16) ref_ch = addr;
        else if (nrise > 0) ref_err++;
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), nrise >= 16 ? 32'd1 : 32'd0);
        chk({tag, "_ch"}, 32'(ch), 32'(ref_ch));
        chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err()));
        wait_clks(HALF);
    endtask
    initial begin
        lnk.sclk = 1'b1;
        lnk.cs_n = 1'b1;
        lnk.din = 1'b0;
        for (int k = 0; k < 8; k++) chdata[k] = 12'($urandom);
        chdata[2] = 12'hA5C;
        ref_ch = '0;
        ref_err = 0;
        wait_clks(4);
        chk("rst_dout", 32'(lnk.dout), 32'd0);
        chk("rst_oe", 32'(lnk.dout_oe), 32'd0);
        chk("rst_ch", 32'(ch), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        wait_clks(HALF);
        run_frame("t1a", 3'd2, 16, 1'b0, 1'b0);
        chk("t1_ch2", 32'(ch), 32'd2);
        run_frame("t1b", 3'd7, 16, 1'b0, 1'b0);
        run_frame("t2a", 3'd0, 16, 1'b0, 1'b0);
        run_frame("t2b", 3'd5, 16, 1'b0, 1'b0);
        run_frame("t3", 3'd3, 9, 1'b0, 1'b0);
        run_frame("t4", 3'd1, 16, 1'b1, 1'b0);
        run_frame("t5", 3'd4, 7, 1'b0, 1'b1);
        run_frame("t5b", 3'd6, 16, 1'b0, 1'b0);
        run_frame("t6", 3'd3, 20, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            int nr;
            case ($urandom_range(0, 2))
                0: nr = 16;
                1: nr = $urandom_range(17, 20);
                default: nr = $urandom_range(1, 15);
            endcase
            run_frame("rnd", 3'($urandom), nr, 1'($urandom), 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
